// File: rtl/counter_pkg.sv
// Shared constants for the parameterised counter family: parameter limits and
// the encoding of the limit-mode input.
package counter_pkg;

   localparam int unsigned MAX_WIDTH    = 32;
   localparam int unsigned MIN_WIDTH    = 2;
   localparam int unsigned MAX_PRESCALE = 65535;
   localparam int unsigned PRE_W        = 16;

   // Behaviour at the count bound: wrap around or stick at the bound.
   typedef enum logic {
      WRAP = 1'b0,
      SAT  = 1'b1
   } limit_mode_e;

endpackage : counter_pkg

// File: rtl/param_counter_tick_divider.sv
// tick_divider: counts enabled edges 0..PRESCALE-1 and emits a one-cycle tick
// on the edge that completes a full PRESCALE period. Only instantiated by
// param_counter when PARAM_COUNTER_PRESCALE_EN is defined.
module tick_divider
   import counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam logic [PRE_W-1:0] LAST_V = PRE_W'(PRESCALE - 1);
   localparam logic [PRE_W-1:0] ONE_V  = PRE_W'(1'b1);
   localparam logic [PRE_W-1:0] ZERO_V = {PRE_W{1'b0}};

   logic [PRE_W-1:0] cnt_q;
   logic [PRE_W-1:0] cnt_d;

   // A tick fires on the enabled edge that finishes the current period.
   assign tick = enable && (cnt_q == LAST_V);

   // Next divider count: clear wins, wrap at the period end, hold when idle.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = ZERO_V;
      end else if (enable) begin
         if (cnt_q == LAST_V) begin
            cnt_d = ZERO_V;
         end else begin
            cnt_d = cnt_q + ONE_V;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Divider state register with asynchronous reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= ZERO_V;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : tick_divider

// File: rtl/param_counter.sv
// param_counter: up/down counter with a programmable upper bound MAX, wrap or
// saturate limit mode, synchronous clear/load and a registered terminal-count
// pulse. Optional enabled-edge prescaler under PARAM_COUNTER_PRESCALE_EN.
module param_counter
   import counter_pkg::*;
#(
   parameter int unsigned     WIDTH    = 8,
   parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
   parameter int unsigned     PRESCALE = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic             up,
   input  logic             saturate,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   // Parameter legality is checked while elaborating so bad builds never run.
   if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
      $error("param_counter: WIDTH %0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
   end
   if ((MAX < 64'd1) || (MAX > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_max
      $error("param_counter: MAX %0d outside 1..2**WIDTH-1", MAX);
   end
   if ((PRESCALE < 1) || (PRESCALE > MAX_PRESCALE)) begin : g_bad_prescale
      $error("param_counter: PRESCALE %0d outside 1..%0d", PRESCALE, MAX_PRESCALE);
   end

   localparam logic [WIDTH-1:0] MAX_V  = MAX[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1'b1);
   localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             tc_q;
   logic             tc_d;
   logic             tick_s;
   logic             step_s;
   limit_mode_e      mode_s;

`ifdef PARAM_COUNTER_PRESCALE_EN
   logic div_clear_s;

   // Any clear or load restarts the prescale period.
   assign div_clear_s = clear | load;

   tick_divider #(
      .PRESCALE (PRESCALE)
   ) u_tick_divider (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (div_clear_s),
      .enable  (enable),
      .tick    (tick_s)
   );
`else
   assign tick_s = 1'b1;
`endif

   assign mode_s = limit_mode_e'(saturate);
   assign step_s = enable & tick_s & ~clear & ~load;

   // Next count and terminal-count: clear > load > step > hold.
   always_comb begin
      q_d  = q_q;
      tc_d = 1'b0;
      if (clear) begin
         q_d = ZERO_V;
      end else if (load) begin
         if (load_value > MAX_V) begin
            q_d = MAX_V;
         end else begin
            q_d = load_value;
         end
      end else if (step_s) begin
         if (up) begin
            if (q_q >= MAX_V) begin
               tc_d = 1'b1;
               q_d  = (mode_s == SAT) ? MAX_V : ZERO_V;
            end else begin
               q_d = q_q + ONE_V;
            end
         end else begin
            if (q_q == ZERO_V) begin
               tc_d = 1'b1;
               q_d  = (mode_s == SAT) ? ZERO_V : MAX_V;
            end else begin
               q_d = q_q - ONE_V;
            end
         end
      end else begin
         q_d = q_q;
      end
   end

   // Count and terminal-count registers with asynchronous reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q_q  <= ZERO_V;
         tc_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         tc_q <= tc_d;
      end
   end

   assign q  = q_q;
   assign tc = tc_q;

endmodule : param_counter

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter (WIDTH=4, MAX=9, PRESCALE=3). Works
// with or without PARAM_COUNTER_PRESCALE_EN; expectations follow the macro.
module tb_param_counter;

   localparam int W   = 4;
   localparam int MX  = 9;
   localparam int PRE = 3;

   typedef struct packed {
      logic [W-1:0] q;
      logic         tc;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         clear;
   logic         load;
   logic [W-1:0] load_value;
   logic         enable;
   logic         up;
   logic         saturate;
   logic [W-1:0] q;
   logic         tc;

   int   n_vec = 0;
   int   n_bad = 0;
   exp_t sb[$];

   // reference model state
   int m_q   = 0;
   int m_tc  = 0;
   int m_div = 0;

   param_counter #(
      .WIDTH    (W),
      .MAX      (64'd9),
      .PRESCALE (PRE)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear      (clear),
      .load       (load),
      .load_value (load_value),
      .enable     (enable),
      .up         (up),
      .saturate   (saturate),
      .q          (q),
      .tc         (tc)
   );

   always #5 clock = ~clock;

   task automatic model_reset();
      m_q   = 0;
      m_tc  = 0;
      m_div = 0;
   endtask

   // Behavioural reference: advance model by one edge and queue the result.
   task automatic drive_edge();
      int  lv;
      bit  tk;
      exp_t e;
      lv = int'(load_value);
      if (clear) begin
         m_q = 0; m_tc = 0; m_div = 0;
      end else if (load) begin
         m_q = (lv > MX) ? MX : lv; m_tc = 0; m_div = 0;
      end else if (enable) begin
`ifdef PARAM_COUNTER_PRESCALE_EN
         m_div = m_div + 1;
         tk = (m_div == PRE);
         if (tk) m_div = 0;
`else
         tk = 1'b1;
`endif
         m_tc = 0;
         if (tk) begin
            if (up) begin
               if (m_q == MX) begin m_tc = 1; m_q = saturate ? MX : 0; end
               else m_q = m_q + 1;
            end else begin
               if (m_q == 0) begin m_tc = 1; m_q = saturate ? 0 : MX; end
               else m_q = m_q - 1;
            end
         end
      end else begin
         m_tc = 0;
      end
      e.q  = W'(m_q);
      e.tc = m_tc[0];
      sb.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic set_in(input bit c, input bit l, input int lv, input bit en,
                         input bit u, input bit s);
      clear = c; load = l; load_value = W'(lv); enable = en; up = u; saturate = s;
   endtask

   task automatic test_reset();
      exp_t e;
      reset_n = 1'b0;
      set_in(0, 0, 0, 0, 1, 0);
      model_reset();
      #12;
      n_vec++;
      if (q !== 4'd0 || tc !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: got q=%0d tc=%0b want q=0 tc=0", q, tc);
      end
      reset_n = 1'b1;
      @(posedge clock); #1;
      // a clear edge starts every later test from a known point
      set_in(1, 0, 0, 0, 1, 0);
      drive_edge();
      e = sb.pop_front();
      n_vec++;
      if (q !== e.q || tc !== e.tc) begin
         n_bad++;
         $display("FAIL reset_clear: got q=%0d tc=%0b want q=%0d tc=%0b", q, tc, e.q, e.tc);
      end
   endtask

   task automatic test_up_wrap();
      exp_t e;
      set_in(1, 0, 0, 0, 1, 0);
      drive_edge();
      void'(sb.pop_front());
      for (int i = 0; i < 12; i++) begin
         set_in(0, 0, 0, 1, 1, 0);
         drive_edge();
         e = sb.pop_front();
         n_vec++;
         if (q !== e.q || tc !== e.tc) begin
            n_bad++;
            $display("FAIL up_wrap[%0d]: got q=%0d tc=%0b want q=%0d tc=%0b", i, q, tc, e.q, e.tc);
         end
      end
   endtask

   task automatic test_down_sat();
      exp_t e;
      set_in(0, 1, 2, 0, 0, 1);
      drive_edge();
      e = sb.pop_front();
      n_vec++;
      if (q !== e.q || tc !== e.tc) begin
         n_bad++;
         $display("FAIL down_sat_load: got q=%0d tc=%0b want q=%0d tc=%0b", q, tc, e.q, e.tc);
      end
      for (int i = 0; i < 12; i++) begin
         set_in(0, 0, 0, 1, 0, 1);
         drive_edge();
         e = sb.pop_front();
         n_vec++;
         if (q !== e.q || tc !== e.tc) begin
            n_bad++;
            $display("FAIL down_sat[%0d]: got q=%0d tc=%0b want q=%0d tc=%0b", i, q, tc, e.q, e.tc);
         end
      end
   endtask

   task automatic test_load_clear();
      exp_t e;
      // rows: clear, load, load_value, enable, up
      int tbl[6][5] = '{'{0,1,15,0,1}, '{0,0,0,1,1}, '{0,1,3,1,1},
                        '{0,1,9,1,0}, '{1,1,7,1,1}, '{0,1,10,0,0}};
      for (int i = 0; i < 6; i++) begin
         set_in(tbl[i][0][0], tbl[i][1][0], tbl[i][2], tbl[i][3][0], tbl[i][4][0], 0);
         drive_edge();
         e = sb.pop_front();
         n_vec++;
         if (q !== e.q || tc !== e.tc) begin
            n_bad++;
            $display("FAIL load_clear[%0d]: got q=%0d tc=%0b want q=%0d tc=%0b", i, q, tc, e.q, e.tc);
         end
      end
      // load_value 15 clamps to 9 regardless of mode
      set_in(0, 1, 15, 1, 1, 1);
      drive_edge();
      void'(sb.pop_front());
      n_vec++;
      if (q !== 4'd9 || tc !== 1'b0) begin
         n_bad++;
         $display("FAIL load_clamp: got q=%0d tc=%0b want q=9 tc=0", q, tc);
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      set_in(0, 1, 4, 0, 1, 0);
      drive_edge();
      void'(sb.pop_front());
      set_in(0, 0, 0, 1, 1, 0);
      drive_edge();
      void'(sb.pop_front());
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (q !== 4'd0 || tc !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset: got q=%0d tc=%0b want q=0 tc=0", q, tc);
      end
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_edge();
         e = sb.pop_front();
         n_vec++;
         if (q !== e.q || tc !== e.tc) begin
            n_bad++;
            $display("FAIL after_reset[%0d]: got q=%0d tc=%0b want q=%0d tc=%0b", i, q, tc, e.q, e.tc);
         end
      end
   endtask

   task automatic test_prescale();
      exp_t e;
      bit   en_pat[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      int   want_final;
`ifdef PARAM_COUNTER_PRESCALE_EN
      want_final = 2;
`else
      want_final = 6;
`endif
      set_in(1, 0, 0, 0, 1, 0);
      drive_edge();
      void'(sb.pop_front());
      for (int i = 0; i < 7; i++) begin
         set_in(0, 0, 0, en_pat[i], 1, 0);
         drive_edge();
         e = sb.pop_front();
         n_vec++;
         if (q !== e.q || tc !== e.tc) begin
            n_bad++;
            $display("FAIL prescale[%0d]: got q=%0d tc=%0b want q=%0d tc=%0b", i, q, tc, e.q, e.tc);
         end
      end
      n_vec++;
      if (int'(q) != want_final) begin
         n_bad++;
         $display("FAIL prescale_final: got q=%0d want q=%0d", q, want_final);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int i = 0; i < 200; i++) begin
         set_in($urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
                int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         drive_edge();
         e = sb.pop_front();
         n_vec++;
         if (q !== e.q || tc !== e.tc || int'(q) > MX) begin
            n_bad++;
            $display("FAIL random[%0d]: got q=%0d tc=%0b want q=%0d tc=%0b", i, q, tc, e.q, e.tc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_sat();
      test_load_clear();
      test_async_reset();
      test_prescale();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_param_counter
